// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: releases the sold product, then pays change as greedy
// large/small coin strobes with per-request ack handshakes and an ack timeout.
module vend_change_dispenser #(
    parameter int COIN_HI     = 10,
    parameter int COIN_LO     = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vend_valid,
    output logic       vend_ready,
    input  logic [1:0] product,
    input  logic [3:0] change,
    output logic       release_valid,
    output logic [1:0] release_product,
    input  logic       release_ack,
    output logic       coin_hi,
    output logic       coin_lo,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RELEASE  = 3'd1;
    localparam logic [2:0] S_PAY      = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [3:0] HI_VAL     = 4'(COIN_HI);
    localparam logic [3:0] LO_VAL     = 4'(COIN_LO);
    localparam logic [3:0] CNT_LAST   = 4'(ACK_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [3:0] r_rem;
    logic [1:0] r_prod;
    logic [3:0] r_cnt;
    logic       r_rem_err;
    logic       r_to_err;
    logic       r_sel_hi;
    logic       w_timeout;

    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_rem_err <= 1'b0;
            r_to_err  <= 1'b0;
            r_sel_hi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (vend_valid) begin
                    r_prod    <= product;
                    r_rem     <= change;
                    r_rem_err <= (int'(change) % COIN_LO) != 0;
                    r_cnt     <= '0;
                    r_state   <= S_RELEASE;
                end
                S_RELEASE: begin
                    // an ack in the final counted cycle still wins over the abort
                    if (release_ack) r_state <= S_PAY;
                    else if (w_timeout) begin
                        r_to_err <= 1'b1;
                        r_state  <= S_DONE;
                    end else r_cnt <= r_cnt + 4'd1;
                end
                S_PAY: begin
                    if (r_rem >= HI_VAL) begin
                        r_sel_hi <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT_ACK;
                    end else if (r_rem >= LO_VAL) begin
                        r_sel_hi <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT_ACK;
                    end else r_state <= S_DONE;
                end
                S_WAIT_ACK: begin
                    if (coin_ack) begin
                        r_rem   <= r_rem - (r_sel_hi ? HI_VAL : LO_VAL);
                        r_state <= S_PAY;
                    end else if (w_timeout) begin
                        r_to_err <= 1'b1;
                        r_state  <= S_DONE;
                    end else r_cnt <= r_cnt + 4'd1;
                end
                S_DONE: begin
                    r_rem_err <= 1'b0;
                    r_to_err  <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vend_ready      = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign release_valid   = (r_state == S_RELEASE);
    assign release_product = r_prod;
    assign coin_hi         = (r_state == S_WAIT_ACK) && r_sel_hi;
    assign coin_lo         = (r_state == S_WAIT_ACK) && !r_sel_hi;
    assign done            = (r_state == S_DONE);
    assign err             = (r_state == S_DONE) && (r_rem_err || r_to_err);
endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb_vend_change_dispenser: directed sales with a queue of expected outcomes
// checked when each done pulse appears.
module tb_vend_change_dispenser;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       vend_valid = 0;
    logic [1:0] product = 0;
    logic [3:0] change = 0;
    logic       release_ack = 0;
    logic       coin_ack = 0;
    logic       vend_ready, release_valid, coin_hi, coin_lo, busy, done, err;
    logic [1:0] release_product;

    typedef struct {int prod; int nhi; int nlo; int err;} exp_t;
    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    bit hold_next = 0;
    logic [1:0] next_p = 0;
    logic [3:0] next_c = 0;

    vend_change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .vend_valid(vend_valid), .vend_ready(vend_ready),
        .product(product), .change(change), .release_valid(release_valid),
        .release_product(release_product), .release_ack(release_ack),
        .coin_hi(coin_hi), .coin_lo(coin_lo), .coin_ack(coin_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after done (or after a mid-sale reset).
    task automatic sale(input logic [1:0] p, input logic [3:0] c, input bit ack_en, input bit rst_mid);
        exp_t e, g;
        int nh = 0, nl = 0, rvc = 0, hilen = 0, maxhi = 0, gaperr = 0, cyc = 0, gprod = -1;
        bit ph = 0, pl = 0, prv = 0, fin = 0;
        vend_valid = 1;
        product = p;
        change = c;
        while (!vend_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc == 50) chk("accept_wait", 0, 1);
        e.prod = p;
        e.nhi = ack_en ? c / 10 : int'(c >= 10);
        e.nlo = ack_en ? (c % 10) / 5 : int'(c < 10 && c >= 5);
        e.err = int'((c % 5 != 0) || (!ack_en && c >= 5));
        q.push_back(e);
        @(negedge clk);
        chk("accepted_release", int'(release_valid), 1);
        if (hold_next) begin
            product = next_p;
            change = next_c;
        end else vend_valid = 0;
        for (cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (release_valid) begin
                rvc += int'(!prv);
                gprod = int'(release_product);
            end
            if (coin_hi && coin_lo) gaperr++;
            if (((coin_hi && !ph) || (coin_lo && !pl)) && (ph || pl)) gaperr++;
            nh += int'(coin_hi && !ph);
            nl += int'(coin_lo && !pl);
            hilen = coin_hi ? hilen + 1 : 0;
            if (hilen > maxhi) maxhi = hilen;
            if (rst_mid && coin_hi) begin
                rst_n = 0;
                #1;
                chk("rst_coin_hi", int'(coin_hi), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_ready", int'(vend_ready), 1);
                chk("rst_rel_prod", int'(release_product), 0);
                void'(q.pop_front());
                release_ack = 0;
                coin_ack = 0;
                vend_valid = 0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_done", int'(done), 0);
                end
                rst_n = 1;
                @(negedge clk);
                chk("rst_release_ready", int'(vend_ready), 1);
                return;
            end
            if (done) begin
                g = q.pop_front();
                chk("prod", gprod, g.prod);
                chk("n_hi", nh, g.nhi);
                chk("n_lo", nl, g.nlo);
                chk("err", int'(err), g.err);
                chk("release_once", rvc, 1);
                chk("coin_gap", gaperr, 0);
                if (!ack_en && c >= 10) chk("hi_hold", maxhi, 15);
                fin = 1;
            end
            release_ack = release_valid && prv;
            coin_ack = ack_en && ((coin_hi && ph) || (coin_lo && pl));
            prv = release_valid;
            ph = coin_hi;
            pl = coin_lo;
            if (!fin) @(negedge clk);
        end
        if (!fin) chk("done_wait", 0, 1);
        release_ack = 0;
        coin_ack = 0;
        @(negedge clk);
        chk("ready_after_done", int'(vend_ready), 1);
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(vend_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_release", int'(release_valid), 0);
        chk("reset_coins", int'({coin_hi, coin_lo}), 0);
        chk("reset_done_err", int'({done, err}), 0);
        chk("reset_rel_prod", int'(release_product), 0);
        rst_n = 1;
        @(negedge clk);
        sale(2'd2, 4'd15, 1, 0);
        sale(2'd0, 4'd0, 1, 0);
        sale(2'd1, 4'd7, 1, 0);
        sale(2'd1, 4'd10, 0, 0);
        sale(2'd2, 4'd15, 1, 1);
        sale(2'd3, 4'd5, 1, 0);
        hold_next = 1;
        next_p = 2'd1;
        next_c = 4'd5;
        sale(2'd2, 4'd15, 1, 0);
        hold_next = 0;
        sale(2'd1, 4'd5, 1, 0);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
